// File: rtl/eeprom_pkg.sv
// Shared definitions for the two-wire EEPROM responder.
// Holds the device-type default, the control-byte field positions, the R/W bit
// encoding and the one-hot FSM state type used by eeprom_slv.
package eeprom_pkg;

  localparam logic [3:0]  DEV_ID_DEF   = 4'b1010;
  localparam int unsigned ADDR_W_DEF   = 11;

  // Control byte layout: {dev_id[3:0], page[2:0], rw}
  localparam int unsigned CTRL_ID_HI   = 7;
  localparam int unsigned CTRL_ID_LO   = 4;
  localparam int unsigned CTRL_PAGE_HI = 3;
  localparam int unsigned CTRL_PAGE_LO = 1;
  localparam int unsigned CTRL_RW      = 0;

  localparam logic        RW_WRITE     = 1'b0;

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    CTRL      = 6'b000010,
    ADDR      = 6'b000100,
    DATA_W    = 6'b001000,
    DATA_R    = 6'b010000,
    WAIT_STOP = 6'b100000
  } state_t;

endpackage

// File: rtl/eeprom_line_sync.sv
// Line conditioning for the two-wire bus: 2-flop synchronizers on scl and sda,
// a one-flop history, and single-cycle event strobes.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   scl, sda    raw bus lines
//   mask        suppresses START/STOP while the responder drives sda
//   scl_rise    synced scl 0->1          scl_fall  synced scl 1->0
//   start       sda 1->0 with scl high   stop      sda 0->1 with scl high
//   sda_s       synced sda level
module eeprom_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  input  logic mask,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [1:0] scl_sy;
  logic [1:0] sda_sy;
  logic       scl_h;
  logic       sda_h;

  // Lines idle high; resetting to 1 avoids a spurious START/STOP out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sy <= '1;
      sda_sy <= '1;
      scl_h  <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_sy <= {scl_sy[0], scl};
      sda_sy <= {sda_sy[0], sda};
      scl_h  <= scl_sy[1];
      sda_h  <= sda_sy[1];
    end
  end

  assign scl_rise = scl_sy[1] & ~scl_h;
  assign scl_fall = ~scl_sy[1] & scl_h;
  assign start    = ~mask & scl_sy[1] & scl_h & sda_h & ~sda_sy[1];
  assign stop     = ~mask & scl_sy[1] & scl_h & ~sda_h & sda_sy[1];
  assign sda_s    = sda_sy[1];

endmodule

// File: rtl/eeprom_slv.sv
// Two-wire EEPROM responder with an internal 2**ADDR_W x 8 array.
// Decodes START/STOP, control, address and data bytes; performs random and
// sequential writes plus random/current-address reads.
// Optional macro SLV_ACK_EN: 9-bit framing with ACK slot (default: 8-bit).
// Ports:
//   clk, reset  system clock (>= 8x scl), synchronous active-high reset
//   scl         serial clock from initiator
//   sda         serial data, push-pull when driving, else high-Z
//   busy        START seen, no STOP yet
//   wr_stb      one-cycle pulse per committed write (wr_addr, wr_data)
//   rd_stb      one-cycle pulse when a read byte starts being driven
module eeprom_slv
  import eeprom_pkg::*;
#(
  parameter logic [3:0]  DEV_ID = DEV_ID_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl,
  inout  logic              sda,
  output logic              busy,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_stb
);

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n, tx_cnt, tx_cnt_n, page, page_n;
  logic [7:0]        shreg, shreg_n, txsh, txsh_n, rx_byte;
  logic [ADDR_W-1:0] ptr, ptr_n, wr_addr_n;
  logic [7:0]        wr_data_n;
  logic              sda_oe, oe_n, busy_n, wr_stb_n, rd_stb_n;
  logic              mem_we, byte_done, rx_en, drv, tx_fall;
  logic              scl_rise, scl_fall, start, stop, sda_s;
  logic [7:0]        mem [2**ADDR_W];

  eeprom_line_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .mask     (sda_oe),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda_s    (sda_s)
  );

  assign sda = sda_oe ? txsh[7] : 1'bz;

`ifdef SLV_ACK_EN
  logic [1:0] ack_ph, ack_ph_n;          // 0 none, 1 armed, 2 driving ACK
  logic       rd_ack_wait, rd_ack_wait_n;
  // ACK drive reuses txsh (loaded with 0); drv separates it from data drive.
  assign rx_en   = (ack_ph == 2'd0) && !rd_ack_wait;
  assign drv     = sda_oe && (ack_ph == 2'd0);
  assign tx_fall = scl_fall && !rd_ack_wait && (ack_ph != 2'd1);
`else
  assign rx_en   = 1'b1;
  assign drv     = sda_oe;
  assign tx_fall = scl_fall;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    tx_cnt_n  = tx_cnt;
    txsh_n    = txsh;
    page_n    = page;
    ptr_n     = ptr;
    oe_n      = sda_oe;
    busy_n    = busy;
    wr_stb_n  = 1'b0;
    rd_stb_n  = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    mem_we    = 1'b0;
    byte_done = 1'b0;
    rx_byte   = {shreg[6:0], sda_s};
`ifdef SLV_ACK_EN
    ack_ph_n      = ack_ph;
    rd_ack_wait_n = rd_ack_wait;
`endif
    if (scl_rise && rx_en) begin
      shreg_n   = rx_byte;
      cnt_n     = cnt + 3'd1;
      byte_done = (cnt == 3'd7);
    end

    // START/STOP pre-empt anything the current state would do this cycle.
    if (start) begin
      state_n = CTRL;
      cnt_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b1;
`ifdef SLV_ACK_EN
      ack_ph_n      = 2'd0;
      rd_ack_wait_n = 1'b0;
`endif
    end else if (stop) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
`ifdef SLV_ACK_EN
      ack_ph_n      = 2'd0;
      rd_ack_wait_n = 1'b0;
`endif
    end else begin
`ifdef SLV_ACK_EN
      if (scl_fall && ack_ph == 2'd1) begin
        oe_n     = 1'b1;
        txsh_n   = '0;
        ack_ph_n = 2'd2;
      end else if (scl_fall && ack_ph == 2'd2) begin
        oe_n     = 1'b0;
        ack_ph_n = 2'd0;
      end
`endif
      case (state)
        IDLE: ;
        CTRL: if (byte_done) begin
          if (rx_byte[CTRL_ID_HI:CTRL_ID_LO] != DEV_ID) begin
            state_n = WAIT_STOP;
          end else begin
`ifdef SLV_ACK_EN
            ack_ph_n = 2'd1;
`endif
            if (rx_byte[CTRL_RW] == RW_WRITE) begin
              page_n  = rx_byte[CTRL_PAGE_HI:CTRL_PAGE_LO];
              state_n = ADDR;
            end else begin
              // Only the page bits are replaced: a preceding ADDR byte
              // (repeated START) keeps its low address bits.
              ptr_n   = ADDR_W'({rx_byte[CTRL_PAGE_HI:CTRL_PAGE_LO], ptr[7:0]});
              state_n = DATA_R;
            end
          end
        end
        ADDR: if (byte_done) begin
          ptr_n   = ADDR_W'({page, rx_byte});
          state_n = DATA_W;
`ifdef SLV_ACK_EN
          ack_ph_n = 2'd1;
`endif
        end
        DATA_W: if (byte_done) begin
          mem_we    = 1'b1;
          wr_stb_n  = 1'b1;
          wr_addr_n = ptr;
          wr_data_n = rx_byte;
          ptr_n     = ptr + 1'b1;
`ifdef SLV_ACK_EN
          ack_ph_n = 2'd1;
`endif
        end
        DATA_R: begin
          if (tx_fall) begin
            if (!drv) begin
              txsh_n   = mem[ptr];
              oe_n     = 1'b1;
              rd_stb_n = 1'b1;
              tx_cnt_n = '0;
            end else if (tx_cnt == 3'd7) begin
              oe_n = 1'b0;
`ifdef SLV_ACK_EN
              rd_ack_wait_n = 1'b1;
`else
              ptr_n   = ptr + 1'b1;
              state_n = WAIT_STOP;
`endif
            end else begin
              txsh_n   = {txsh[6:0], 1'b0};
              tx_cnt_n = tx_cnt + 3'd1;
            end
          end
`ifdef SLV_ACK_EN
          if (scl_rise && rd_ack_wait) begin
            rd_ack_wait_n = 1'b0;
            if (!sda_s) ptr_n = ptr + 1'b1;
            else        state_n = WAIT_STOP;
          end
`endif
        end
        WAIT_STOP: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      tx_cnt  <= '0;
      txsh    <= '0;
      page    <= '0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      rd_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
`ifdef SLV_ACK_EN
      ack_ph      <= 2'd0;
      rd_ack_wait <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      tx_cnt  <= tx_cnt_n;
      txsh    <= txsh_n;
      page    <= page_n;
      ptr     <= ptr_n;
      sda_oe  <= oe_n;
      busy    <= busy_n;
      wr_stb  <= wr_stb_n;
      rd_stb  <= rd_stb_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
`ifdef SLV_ACK_EN
      ack_ph      <= ack_ph_n;
      rd_ack_wait <= rd_ack_wait_n;
`endif
    end
  end

  // Array is deliberately outside reset: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= rx_byte;
  end

endmodule

// File: tb/tb_eeprom_slv.sv
// Self-checking bench for eeprom_slv (default 8-bit framing).
// An initiator model drives scl/sda; expected writes and read bytes come from
// a behavioural array model and go into queues consumed by a monitor process.
module tb_eeprom_slv;

  localparam logic [3:0] DEV = 4'hA;

  logic        clk = 1'b0;
  logic        reset, scl, m_low;
  wire         sda;
  logic        busy, wr_stb, rd_stb;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  eeprom_slv #(.DEV_ID(4'b1010), .ADDR_W(11)) dut (
    .clk     (clk),
    .reset   (reset),
    .scl     (scl),
    .sda     (sda),
    .busy    (busy),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_stb  (rd_stb)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; int n; } rd_exp_t;

  logic [18:0] exp_wr[$];
  rd_exp_t     exp_rd[$];
  logic [7:0]  mem_m [2048];
  logic [7:0]  wdat[$];
  int          ptr_m;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic        oe_watch, oe_seen;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      clk_n(6); m_low = 1'b0; clk_n(2); scl = 1'b1; clk_n(8);
    end
    m_low = 1'b1; clk_n(8); scl = 1'b0;
  endtask

  task automatic bus_stop();
    clk_n(6); m_low = 1'b1; clk_n(2); scl = 1'b1; clk_n(8); m_low = 1'b0; clk_n(8);
  endtask

  task automatic send_bit(input logic b);
    clk_n(6); m_low = ~b; clk_n(2); scl = 1'b1; clk_n(8); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic recv_bits(input int n);
    for (int i = 0; i < n; i++) begin
      clk_n(6); m_low = 1'b0; clk_n(2); scl = 1'b1; clk_n(8); scl = 1'b0;
    end
  endtask

  task automatic do_write(input logic [10:0] a);
    bus_start();
    send_byte({DEV, a[10:8], 1'b0});
    chk("busy_in_xfer", busy, 1);
    send_byte(a[7:0]);
    ptr_m = a;
    foreach (wdat[i]) begin
      exp_wr.push_back({11'(ptr_m), wdat[i]});
      mem_m[ptr_m] = wdat[i];
      send_byte(wdat[i]);
      ptr_m = (ptr_m + 1) % 2048;
    end
    bus_stop();
    chk("busy_after_stop", busy, 0);
  endtask

  task automatic do_rand_read(input logic [10:0] a);
    rd_exp_t e;
    bus_start();
    send_byte({DEV, a[10:8], 1'b0});
    send_byte(a[7:0]);
    bus_start();
    send_byte({DEV, a[10:8], 1'b1});
    ptr_m = a;
    e.b = mem_m[ptr_m]; e.n = 8;
    exp_rd.push_back(e);
    recv_bits(8);
    ptr_m = (ptr_m + 1) % 2048;
    bus_stop();
  endtask

  task automatic do_cur_read();
    rd_exp_t    e;
    logic [10:0] p;
    p = 11'(ptr_m);
    bus_start();
    send_byte({DEV, p[10:8], 1'b1});
    e.b = mem_m[ptr_m]; e.n = 8;
    exp_rd.push_back(e);
    recv_bits(8);
    ptr_m = (ptr_m + 1) % 2048;
    bus_stop();
  endtask

  // Monitor: compares every DUT output event against the queued expectation.
  initial begin
    logic [18:0] e;
    rd_exp_t     r;
    logic [7:0]  got;
    forever begin
      @(negedge clk);
      if (oe_watch && dut.sda_oe) oe_seen = 1'b1;
      if (wr_stb) begin
        if (exp_wr.size() == 0) begin
          total_cnt++;
          $display("FAIL wr_unexpected: addr %0h data %0h, none expected", wr_addr, wr_data);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", wr_addr, e[18:8]);
          chk("wr_data", wr_data, e[7:0]);
        end
      end
      if (rd_stb) begin
        if (exp_rd.size() == 0) begin
          total_cnt++;
          $display("FAIL rd_unexpected: rd_stb with no read expected");
        end else begin
          r = exp_rd.pop_front();
          got = '0;
          for (int i = 0; i < r.n; i++) begin
            @(posedge scl);
            repeat (4) @(negedge clk);
            got = {got[6:0], sda};
          end
          chk("rd_bits", got, r.b >> (8 - r.n));
        end
      end
    end
  end

  initial begin
    #800000;
    total_cnt++;
    $display("FAIL watchdog: sequence did not complete in time");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    logic [10:0] a;
    int          n;
    rd_exp_t     e;
    reset = 1'b1; scl = 1'b1; m_low = 1'b0; oe_watch = 1'b0; oe_seen = 1'b0; ptr_m = 0;
    clk_n(5);
    chk("rst_busy", busy, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_rd_stb", rd_stb, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_sda", sda, 1);
    reset = 1'b0;
    clk_n(4);

    wdat = '{8'h5A};
    do_write(11'h235);
    do_rand_read(11'h235);

    wdat = '{8'h11, 8'h22};
    do_write(11'h7FF);
    do_rand_read(11'h7FF);
    do_cur_read();

    // Foreign device code: no write, no drive, busy until STOP.
    oe_watch = 1'b1;
    bus_start();
    send_byte(8'hB0); send_byte(8'h35); send_byte(8'h77);
    chk("busy_mismatch", busy, 1);
    bus_stop();
    chk("busy_mismatch_stop", busy, 0);
    bus_start();
    send_byte(8'hB1);
    recv_bits(8);
    bus_stop();
    oe_watch = 1'b0;
    chk("oe_mismatch", oe_seen, 0);

    // Reset while bit4 of a read byte is on the bus.
    wdat = '{8'hC3};
    do_write(11'h3A6);
    a = 11'h3A6;
    bus_start();
    send_byte({DEV, a[10:8], 1'b0});
    send_byte(a[7:0]);
    bus_start();
    send_byte({DEV, a[10:8], 1'b1});
    e.b = mem_m[a]; e.n = 3;
    exp_rd.push_back(e);
    recv_bits(3);
    clk_n(6);
    chk("sda_bit4_driven", sda, mem_m[a][4]);
    reset = 1'b1;
    clk_n(1);
    chk("sda_released_reset", sda, 1);
    chk("busy_reset", busy, 0);
    clk_n(2);
    reset = 1'b0;
    ptr_m = 0;
    do_rand_read(11'h3A6);

    for (int it = 0; it < 8; it++) begin
      a = 11'($urandom_range(0, 2047));
      n = $urandom_range(1, 4);
      wdat.delete();
      for (int k = 0; k < n; k++) wdat.push_back(8'($urandom));
      do_write(a);
      do_rand_read(a);
      for (int k = 1; k < n; k++) do_cur_read();
    end

    clk_n(50);
    chk("exp_wr_left", exp_wr.size(), 0);
    chk("exp_rd_left", exp_rd.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
